// File: rtl/qdr_init_seq.sv
`timescale 1ns/1ps
// qdr_init_seq: QDR PHY reset/calibration sequencer with a Wishbone status/control block.
// Define QDR_INIT_AUTOSTART_EN to issue an internal start on the first clock after reset.
//   state | meaning
//   IDLE  | waiting for a start
//   RST   | qdr_reset asserted for RST_CYCLES clocks
//   WAIT  | waiting for phy_ready, timeout counter running
//   UP    | memory usable
//   FAIL  | retries exhausted, waiting for start or abort
module qdr_init_seq #(
    parameter int RETRY_MAX      = 3,
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        phy_ready,
    input  logic        cal_fail,
    output logic        qdr_reset,
    output logic        qdr_up,
    output logic        init_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RST  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_UP   = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

    localparam logic [7:0]  RST_LOAD  = 8'(RST_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIM = 4'(RETRY_MAX);

    logic [2:0]  state;
    logic [7:0]  rst_cnt;
    logic [15:0] tmo_cnt;
    logic [3:0]  retry_cnt;
    logic [7:0]  drop_cnt;
    logic        start_p;
    logic        abort_p;
    logic        start_evt;
    logic        bus_req;
    logic        ctrl_wr;
    logic [2:0]  reg_sel;
    logic [15:0] rd_data;
    logic        unused_bits;

    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[0], wb_sel_i[1], wb_dat_i[15:2]};

`ifdef QDR_INIT_AUTOSTART_EN
    logic auto_pend;

    always_ff @(posedge wb_clk_i) begin
        auto_pend <= wb_rst_i;
    end

    assign start_evt = start_p | auto_pend;
`else
    assign start_evt = start_p;
`endif

    assign bus_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign reg_sel = wb_adr_i[3:1];
    assign ctrl_wr = bus_req & wb_we_i & wb_sel_i[0] & (reg_sel == 3'd1);

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            3'd0:    rd_data = {6'd0, init_err, qdr_up, 2'd0, cal_fail, phy_ready, 1'b0, state};
            3'd2:    rd_data = {drop_cnt, 4'd0, retry_cnt};
            3'd3:    rd_data = tmo_cnt;
            default: rd_data = '0;
        endcase
    end

    // Control bits are captured at the acking edge and act as one-clock pulses after it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            start_p  <= 1'b0;
            abort_p  <= 1'b0;
        end else begin
            wb_ack_o <= bus_req;
            wb_dat_o <= (bus_req & ~wb_we_i) ? rd_data : 16'd0;
            start_p  <= ctrl_wr & wb_dat_i[0];
            abort_p  <= ctrl_wr & wb_dat_i[1];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            rst_cnt   <= '0;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            drop_cnt  <= '0;
        end else if (abort_p) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_FAIL: begin
                    if (start_evt) begin
                        retry_cnt <= '0;
                        rst_cnt   <= RST_LOAD;
                        state     <= S_RST;
                    end
                end
                S_RST: begin
                    if (rst_cnt == 8'd0) begin
                        tmo_cnt <= '0;
                        state   <= S_WAIT;
                    end else begin
                        rst_cnt <= rst_cnt - 8'd1;
                    end
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    // cal_fail beats phy_ready; phy_ready beats a coincident timeout
                    if (cal_fail || (!phy_ready && tmo_cnt == TMO_LAST)) begin
                        if (retry_cnt < RETRY_LIM) begin
                            retry_cnt <= retry_cnt + 4'd1;
                            rst_cnt   <= RST_LOAD;
                            state     <= S_RST;
                        end else begin
                            state <= S_FAIL;
                        end
                    end else if (phy_ready) begin
                        state <= S_UP;
                    end
                end
                S_UP: begin
                    if (!phy_ready) begin
                        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                        retry_cnt <= '0;
                        rst_cnt   <= RST_LOAD;
                        state     <= S_RST;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign qdr_reset = (state == S_RST);
    assign qdr_up    = (state == S_UP);
    assign init_err  = (state == S_FAIL);

endmodule

// File: doc/qdr_init_seq.md
QDR_INIT_SEQ -- requirements
Module: qdr_init_seq

Interface
REQ-001 Parameter RETRY_MAX, default 3: calibration retries allowed after the first attempt; range 0-15.
REQ-002 Parameter RST_CYCLES, default 16: qdr_reset pulse width in clocks; range 1-255.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535: clocks to wait for phy_ready per attempt; range 1-65535.
REQ-004 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe and write-enable.
REQ-007 wb_sel_i  in  2  byte selects; bit0 qualifies writes to wb_dat_i[7:0].
REQ-008 wb_adr_i  in  32  byte address; only [3:1] decoded.
REQ-009 wb_dat_i  in  16 / wb_dat_o  out  16  write data / registered read data.
REQ-010 wb_ack_o  out  1  single-cycle acknowledge.
REQ-011 phy_ready, cal_fail  in  1 each  PHY status, synchronous to wb_clk_i.
REQ-012 qdr_reset  out  1  PHY reset; qdr_up  out  1  memory usable; init_err  out  1  retries exhausted.

Function
REQ-013 FSM states: IDLE=0, RST=1, WAIT=2, UP=3, FAIL=4; the 3-bit encoding is software-visible.
REQ-014 IDLE: on start, clear retry_cnt, go to RST.
REQ-015 RST: qdr_reset=1 for exactly RST_CYCLES clocks, then go to WAIT with the timeout counter cleared.
REQ-016 WAIT: qdr_reset=0; the timeout counter increments each clock.
REQ-017 WAIT, phy_ready=1 and cal_fail=0: go to UP.
REQ-018 WAIT, cal_fail=1 (takes priority over a simultaneous phy_ready), or counter reaching TIMEOUT_CYCLES: if retry_cnt<RETRY_MAX, increment retry_cnt and go to RST; otherwise go to FAIL.
REQ-019 UP: qdr_up=1.
REQ-020 UP, phy_ready falls: increment drop_cnt (8-bit, saturating at 255), clear retry_cnt, go to RST.
REQ-021 FAIL: init_err=1; remain until start or abort.
REQ-022 FAIL, start: clear retry_cnt, go to RST.
REQ-023 Abort, any state: go to IDLE next clock; qdr_reset, qdr_up and init_err deassert that same clock.
REQ-024 Abort outranks start when both are written in the same cycle.
REQ-025 Start in RST, WAIT or UP is ignored.
REQ-026 Wishbone: ack=1 one clock after cyc&stb&~ack; ack=0 the following clock; no back-to-back acks.
REQ-027 Read data is registered with the ack; reads have no side effects.
REQ-028 Register map by wb_adr_i[3:1]:
  0 STATUS (RO): [2:0] state, [4] phy_ready, [5] cal_fail, [8] qdr_up, [9] init_err.
  1 CONTROL (WO, reads 0): [0] start, [1] abort; self-clearing pulses; require wb_sel_i[0].
  2 RETRY (RO): [3:0] retry_cnt, [15:8] drop_cnt.
  3 TIMEOUT (RO): timeout counter value.
  4-7: read 0, writes ignored.
REQ-029 CONTROL write pulses act on the clock after the acked write; the FSM sees them at most one cycle later.
REQ-030 drop_cnt is cleared only by reset.

Reset
REQ-031 On wb_rst_i: state=IDLE, qdr_reset=0, qdr_up=0, init_err=0, wb_ack_o=0, wb_dat_o=0, retry_cnt=0, drop_cnt=0, timeout counter=0.
REQ-032 Reset mid-operation, including mid-pulse in RST or mid-Wishbone-cycle, takes effect the next clock; no ack is issued for the interrupted cycle.

Configuration
REQ-033 Macro QDR_INIT_AUTOSTART_EN.
REQ-034 Defined: the FSM generates an internal start on the first clock after wb_rst_i deasserts, so IDLE->RST happens without software.
REQ-035 Undefined: the FSM stays in IDLE until a CONTROL start write.
REQ-036 Abort behaviour is identical in both builds; after an abort, a start write is always required.

Verification
REQ-037 Defaults, macro undefined: write CONTROL=0x0001; phy_ready=1 at 40 clocks -> qdr_reset high exactly 16 clocks; STATUS=0x0113 (UP, qdr_up=1, phy_ready=1, cal_fail=0); RETRY=0x0000.
REQ-038 cal_fail pulsed in WAIT four times -> three further 16-clock reset pulses; then STATUS state=4, init_err=1; RETRY[3:0]=3.
REQ-039 TIMEOUT_CYCLES=100, phy_ready held 0 -> each WAIT lasts 100 clocks; FAIL after 4 attempts; TIMEOUT reads 100 in FAIL.
REQ-040 In UP, drop phy_ready for 1 clock -> drop_cnt=1, retry_cnt=0, new reset pulse; phy_ready and cal_fail both asserted in WAIT -> counted as a failure, not UP.
REQ-041 Write CONTROL=0x0003 in WAIT -> IDLE next FSM clock, qdr_reset=0; build with QDR_INIT_AUTOSTART_EN -> qdr_reset rises 1 clock after reset release, with no bus traffic.
REQ-042 Reset asserted mid-RST pulse -> all outputs 0 the next clock; reads of addresses 5-7 return 0x0000 with a single-cycle ack.
